sbox_share_arbiter: RTL



---
 rtl/sbox_share_arbiter.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sbox_share_arbiter.sv
// ---------------------------------------------------------------------------
// sbox_share_arbiter
//
// Time-multiplexed SubBytes / SubWord engine. A bank of four byte S-boxes
// (one 32-bit column) is shared between the cipher state datapath and the
// key expansion unit. A 128-bit SubBytes takes four passes through the bank
// and a 32-bit SubWord takes one pass.
//
// Optional feature macro: SBOX_RR_EN
//   defined   -> round-robin tie-break between simultaneous requests
//   undefined -> fixed priority, key beats state on a tie
//
// Ports
//   clk      in   1    rising-edge clock
//   rst      in   1    asynchronous reset, active high
//   st_req   in   1    state SubBytes request (level)
//   st_in    in   128  state operand, byte 15 in bits 127:120
//   st_gnt   out  1    one-cycle pulse, state request accepted
//   st_done  out  1    one-cycle pulse, st_out complete
//   st_out   out  128  SubBytes result register
//   kw_req   in   1    key-word SubWord request (level)
//   kw_in    in   32   key word operand
//   kw_gnt   out  1    one-cycle pulse, key request accepted
//   kw_done  out  1    one-cycle pulse, kw_out complete
//   kw_out   out  32   SubWord result register
//   busy     out  1    high while a pass sequence is running
// ---------------------------------------------------------------------------

// AES forward S-box for one byte: multiplicative inverse in GF(2^8)
// (modulus x^8+x^4+x^3+x+1) followed by the AES affine transform.
module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) begin
                acc = acc ^ x;
            end else begin
                acc = acc;
            end
            if (x[7]) begin
                x = {x[6:0], 1'b0} ^ 8'h1b;
            end else begin
                x = {x[6:0], 1'b0};
            end
        end
        return acc;
    endfunction

    // Inverse as v^254 = v^2 * v^4 * ... * v^128; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] v);
        logic [7:0] sq;
        logic [7:0] r;
        sq = v;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] s);
        return s
             ^ {s[6:0], s[7]}
             ^ {s[5:0], s[7:6]}
             ^ {s[4:0], s[7:5]}
             ^ {s[3:0], s[7:4]}
             ^ 8'h63;
    endfunction

    logic [7:0] inv_s;

    // Pure combinational byte substitution.
    always_comb begin
        inv_s = gf_inv(a);
        y     = affine(inv_s);
    end

endmodule

module sbox_share_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_req,
    input  logic [127:0] st_in,
    output logic         st_gnt,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         kw_req,
    input  logic [31:0]  kw_in,
    output logic         kw_gnt,
    output logic         kw_done,
    output logic [31:0]  kw_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_RUN = 2'd1,
        KW_RUN = 2'd2
    } state_t;

    state_t         state_r;
    logic [1:0]     cnt_r;
    logic [127:0]   op_r;
    logic [127:0]   st_out_r;
    logic [31:0]    kw_out_r;
    logic           st_gnt_r;
    logic           st_done_r;
    logic           kw_gnt_r;
    logic           kw_done_r;
    logic           busy_r;

    logic [31:0]    bank_in_s;
    logic [31:0]    bank_out_s;
    logic           grant_kw_s;
    logic           grant_st_s;

`ifdef SBOX_RR_EN
    // High when the key side wins the next tie; reset favours key.
    logic           prio_kw_r;

    // Tie-break by the round-robin pointer; single requests win outright.
    always_comb begin
        if (kw_req && st_req) begin
            grant_kw_s = prio_kw_r;
        end else begin
            grant_kw_s = kw_req;
        end
        grant_st_s = st_req && !grant_kw_s;
    end

    // After each grant the other requester becomes favoured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_kw_r <= 1'b1;
        end else if ((state_r == IDLE) && (grant_kw_s || grant_st_s)) begin
            prio_kw_r <= grant_st_s;
        end else begin
            prio_kw_r <= prio_kw_r;
        end
    end
`else
    // Fixed priority: key always beats state.
    always_comb begin
        grant_kw_s = kw_req;
        grant_st_s = st_req && !kw_req;
    end
`endif

    // Select the operand column presented to the shared S-box bank.
    always_comb begin
        bank_in_s = op_r[31:0];
        case (state_r)
            ST_RUN: begin
                case (cnt_r)
                    2'd0:    bank_in_s = op_r[127:96];
                    2'd1:    bank_in_s = op_r[95:64];
                    2'd2:    bank_in_s = op_r[63:32];
                    default: bank_in_s = op_r[31:0];
                endcase
            end
            default: begin
                bank_in_s = op_r[31:0];
            end
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_bank
        sbox u_sbox (
            .a (bank_in_s[8*g +: 8]),
            .y (bank_out_s[8*g +: 8])
        );
    end

    // Arbitration, pass sequencing and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 2'd0;
            op_r      <= 128'h0;
            st_out_r  <= 128'h0;
            kw_out_r  <= 32'h0;
            st_gnt_r  <= 1'b0;
            st_done_r <= 1'b0;
            kw_gnt_r  <= 1'b0;
            kw_done_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            st_gnt_r  <= 1'b0;
            st_done_r <= 1'b0;
            kw_gnt_r  <= 1'b0;
            kw_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_kw_s) begin
                        op_r[31:0] <= kw_in;
                        kw_gnt_r   <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= KW_RUN;
                    end else if (grant_st_s) begin
                        op_r     <= st_in;
                        st_gnt_r <= 1'b1;
                        busy_r   <= 1'b1;
                        cnt_r    <= 2'd0;
                        state_r  <= ST_RUN;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Result lands in the same word lane it was read from.
                    case (cnt_r)
                        2'd0:    st_out_r[127:96] <= bank_out_s;
                        2'd1:    st_out_r[95:64]  <= bank_out_s;
                        2'd2:    st_out_r[63:32]  <= bank_out_s;
                        default: st_out_r[31:0]   <= bank_out_s;
                    endcase
                    if (cnt_r == 2'd3) begin
                        st_done_r <= 1'b1;
                        busy_r    <= 1'b0;
                        cnt_r     <= 2'd0;
                        state_r   <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + 2'd1;
                    end
                end
                KW_RUN: begin
                    kw_out_r  <= bank_out_s;
                    kw_done_r <= 1'b1;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    cnt_r   <= 2'd0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign st_gnt  = st_gnt_r;
    assign st_done = st_done_r;
    assign st_out  = st_out_r;
    assign kw_gnt  = kw_gnt_r;
    assign kw_done = kw_done_r;
    assign kw_out  = kw_out_r;
    assign busy    = busy_r;

endmodule
